pipe_control: RTL

Registered, hazard-aware control unit for the 4-bit-opcode pipelined datapath, replacing the purely combinational opcode decoder. It decodes the opcode in ID, then carries the EX and MEM control bundles with the destination register through ID/EX and EX/MEM pipeline registers. It also detects load-use hazards, inserts bubbles, squashes younger instructions on flush, and flags illegal opcodes. It sits between the instruction register and the datapath control lines.

---
 rtl/pipe_control.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipe_control.sv
// Registered pipeline control: ID decode into ID/EX and EX/MEM control registers,
// with squash on flush and illegal-opcode flagging. Load-use detection is built when
// PIPE_CONTROL_HAZARD_EN is defined. Otherwise stall_o is 0, and software must put a
// delay slot after each LD.
module pipe_control #(
  parameter int REG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [3:0]       opcode_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [4:0]       ex_ctrl_o,
  output logic [REG_W-1:0] ex_rd_o,
  output logic [6:0]       mem_ctrl_o,
  output logic [REG_W-1:0] mem_rd_o,
  output logic             illegal_o
);

  localparam logic [4:0] EX_NOP  = 5'b01100;
  localparam logic [6:0] MEM_NOP = 7'b0000000;

  logic [4:0]       dec_ex;
  logic [6:0]       dec_mem;
  logic             dec_ill;
  logic [REG_W-1:0] dec_rd;
  logic [6:0]       idex_mem_q;
  logic             load_use;

  // An invalid ID slot enters the pipe exactly like a bubble.
  always_comb begin
    dec_ex  = EX_NOP;
    dec_mem = MEM_NOP;
    dec_ill = 1'b0;
    dec_rd  = '0;
    if (valid_i) begin
      dec_rd = rd_i;
      unique case (opcode_i)
        4'b0000: begin dec_ex = 5'b01100; dec_mem = 7'b0000000; end
        4'b1111: begin dec_ex = 5'b11100; dec_mem = 7'b1010000; end
        4'b1110: begin dec_ex = 5'b11110; dec_mem = 7'b1100000; end
        4'b0011: begin dec_ex = 5'b11101; dec_mem = 7'b0000000; end
        4'b0100: begin dec_ex = 5'b10000; dec_mem = 7'b1000000; end
        4'b0101: begin dec_ex = 5'b01000; dec_mem = 7'b1000000; end
        4'b0110: begin dec_ex = 5'b00100; dec_mem = 7'b1000000; end
        4'b0111: begin dec_ex = 5'b00000; dec_mem = 7'b1000000; end
        4'b1000: begin dec_ex = 5'b01100; dec_mem = 7'b0001000; end
        4'b1001: begin dec_ex = 5'b01100; dec_mem = 7'b0000001; end
        4'b1010: begin dec_ex = 5'b00110; dec_mem = 7'b0000100; end
        4'b1011: begin dec_ex = 5'b01100; dec_mem = 7'b0000010; end
        default: dec_ill = 1'b1;
      endcase
    end
  end

`ifdef PIPE_CONTROL_HAZARD_EN
  // MemRead together with MemToReg marks an LD. JM also reads memory but writes PC, not a register.
  assign load_use = valid_i && ex_ctrl_o[1] && idex_mem_q[5] &&
                    ((ex_rd_o == rs_i) || (ex_rd_o == rt_i));
`else
  logic unused_srcs;
  assign unused_srcs = ^{rs_i, rt_i};
  assign load_use    = 1'b0;
`endif

  assign stall_o = load_use && rst_n && en_i && !flush_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl_o  <= EX_NOP;
      idex_mem_q <= MEM_NOP;
      ex_rd_o    <= '0;
      illegal_o  <= 1'b0;
      mem_ctrl_o <= MEM_NOP;
      mem_rd_o   <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        ex_ctrl_o  <= EX_NOP;
        idex_mem_q <= MEM_NOP;
        ex_rd_o    <= '0;
        illegal_o  <= 1'b0;
        mem_ctrl_o <= MEM_NOP;
        mem_rd_o   <= '0;
      end else begin
        mem_ctrl_o <= idex_mem_q;
        mem_rd_o   <= ex_rd_o;
        if (stall_o) begin
          ex_ctrl_o  <= EX_NOP;
          idex_mem_q <= MEM_NOP;
          ex_rd_o    <= '0;
          illegal_o  <= 1'b0;
        end else begin
          ex_ctrl_o  <= dec_ex;
          idex_mem_q <= dec_mem;
          ex_rd_o    <= dec_rd;
          illegal_o  <= dec_ill;
        end
      end
    end
  end

endmodule
